// File: rtl/rej_bounded_sampler.sv
// rej_bounded_sampler: streaming bounded-coefficient sampler.
// Absorbs a seed into an external SHAKE256 sponge, squeezes words and
// rejection-samples 4-bit nibbles into N coefficients in [-eta, eta].
// Optional feature macro: REJ_CNT_EN adds a 16-bit rejected-nibble counter port.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start; outputs quiet
// S_INIT   | one-cycle sponge clear pulse
// S_ABSORB | feed seed words to the sponge, last word flagged
// S_FETCH  | accept one squeezed word into the nibble buffer
// S_SAMPLE | one nibble per cycle, accepted ones go to the output register
// S_DONE   | one-cycle done pulse, then back to idle
module rej_bounded_sampler #(
    parameter int N             = 256,
    parameter int COEFF_WIDTH   = 4,
    parameter int SEED_BYTES    = 66,
    parameter int DATA_IN_BITS  = 64,
    parameter int DATA_OUT_BITS = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              eta_sel,
    input  logic [SEED_BYTES*8-1:0]           seed,
    output logic                              busy,
    output logic                              done,
    output logic [COEFF_WIDTH-1:0]            coeff_data,
    output logic [$clog2(N)-1:0]              coeff_idx,
    output logic                              coeff_valid,
    input  logic                              coeff_ready,
    output logic                              sp_init,
    output logic [DATA_IN_BITS-1:0]           sp_data_in,
    output logic                              sp_in_valid,
    output logic                              sp_in_last,
    output logic [$clog2(DATA_IN_BITS):0]     sp_last_len,
    input  logic                              sp_in_ready,
    input  logic [DATA_OUT_BITS-1:0]          sp_data_out,
    input  logic                              sp_out_valid,
    output logic                              sp_out_ready
`ifdef REJ_CNT_EN
    ,
    output logic [15:0]                       rej_cnt
`endif
);

    localparam int SEED_BITS  = SEED_BYTES * 8;
    localparam int N_IN_WORDS = (SEED_BITS + DATA_IN_BITS - 1) / DATA_IN_BITS;
    localparam int PAD_BITS   = N_IN_WORDS * DATA_IN_BITS;
    localparam int LAST_BITS  = SEED_BITS - (N_IN_WORDS - 1) * DATA_IN_BITS;
    localparam int IDX_W      = $clog2(N);
    localparam int CNT_W      = $clog2(N + 1);
    localparam int LEN_W      = $clog2(DATA_IN_BITS) + 1;
    localparam int NIBS       = DATA_OUT_BITS / 4;
    localparam int PTR_W      = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int K_W        = (N_IN_WORDS > 1) ? $clog2(N_IN_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ABSORB,
        S_FETCH,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [SEED_BITS-1:0]       seed_q, seed_d;
    logic                       eta4_q, eta4_d;
    logic [K_W-1:0]             abs_k_q, abs_k_d;
    logic [DATA_OUT_BITS-1:0]   buf_q, buf_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic [CNT_W-1:0]           acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]           hs_cnt_q, hs_cnt_d;
    logic [COEFF_WIDTH-1:0]     coeff_data_q, coeff_data_d;
    logic [IDX_W-1:0]           coeff_idx_q, coeff_idx_d;
    logic                       coeff_valid_q, coeff_valid_d;
`ifdef REJ_CNT_EN
    logic [15:0]                rej_cnt_q, rej_cnt_d;
`endif

    logic [PAD_BITS-1:0]        seed_pad;
    logic [3:0]                 nib;
    logic [3:0]                 nib_mod5;
    logic                       nib_accept;
    logic [COEFF_WIDTH-1:0]     nib_coeff;
    logic                       handoff;
    logic                       advance;
    logic                       abs_last_word;

    // Zero-pad the latched seed up to a whole number of absorb words.
    always_comb begin
        seed_pad                = '0;
        seed_pad[SEED_BITS-1:0] = seed_q;
    end

    // Current nibble and its mapping to a coefficient for the latched eta.
    always_comb begin
        nib      = buf_q[int'(ptr_q)*4 +: 4];
        nib_mod5 = nib;
        if (nib >= 4'd10) begin
            nib_mod5 = nib - 4'd10;
        end else if (nib >= 4'd5) begin
            nib_mod5 = nib - 4'd5;
        end
        if (eta4_q) begin
            nib_accept = (nib < 4'd9);
            nib_coeff  = COEFF_WIDTH'(4) - COEFF_WIDTH'(nib);
        end else begin
            nib_accept = (nib < 4'd15);
            nib_coeff  = COEFF_WIDTH'(2) - COEFF_WIDTH'(nib_mod5);
        end
    end

    assign handoff       = coeff_valid_q & coeff_ready;
    assign advance       = ~coeff_valid_q | coeff_ready;
    assign abs_last_word = (abs_k_q == K_W'(N_IN_WORDS - 1));

    // Next-state and datapath updates; the output register hands off in any state.
    always_comb begin
        state_d       = state_q;
        seed_d        = seed_q;
        eta4_d        = eta4_q;
        abs_k_d       = abs_k_q;
        buf_d         = buf_q;
        ptr_d         = ptr_q;
        acc_cnt_d     = acc_cnt_q;
        hs_cnt_d      = hs_cnt_q;
        coeff_data_d  = coeff_data_q;
        coeff_idx_d   = coeff_idx_q;
        coeff_valid_d = coeff_valid_q;
`ifdef REJ_CNT_EN
        rej_cnt_d     = rej_cnt_q;
`endif

        if (handoff) begin
            coeff_valid_d = 1'b0;
            hs_cnt_d      = hs_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_INIT;
                    seed_d        = seed;
                    eta4_d        = eta_sel;
                    abs_k_d       = '0;
                    ptr_d         = '0;
                    acc_cnt_d     = '0;
                    hs_cnt_d      = '0;
                    coeff_valid_d = 1'b0;
`ifdef REJ_CNT_EN
                    rej_cnt_d     = '0;
`endif
                end
            end
            S_INIT: begin
                state_d = S_ABSORB;
            end
            S_ABSORB: begin
                if (sp_in_ready) begin
                    if (abs_last_word) begin
                        state_d = S_FETCH;
                    end else begin
                        abs_k_d = abs_k_q + K_W'(1);
                    end
                end
            end
            S_FETCH: begin
                if (sp_out_valid) begin
                    buf_d   = sp_data_out;
                    ptr_d   = '0;
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (acc_cnt_q < CNT_W'(N)) begin
                    if (advance) begin
                        if (nib_accept) begin
                            coeff_data_d  = nib_coeff;
                            coeff_idx_d   = IDX_W'(acc_cnt_q);
                            coeff_valid_d = 1'b1;
                            acc_cnt_d     = acc_cnt_q + CNT_W'(1);
                        end else begin
`ifdef REJ_CNT_EN
                            if (rej_cnt_q != 16'hFFFF) begin
                                rej_cnt_d = rej_cnt_q + 16'd1;
                            end
`endif
                        end
                        ptr_d = ptr_q + PTR_W'(1);
                        // Refill only if this nibble did not complete the polynomial.
                        if ((ptr_q == PTR_W'(NIBS - 1)) &&
                            !(nib_accept && (acc_cnt_q == CNT_W'(N - 1)))) begin
                            state_d = S_FETCH;
                        end
                    end
                end else if (hs_cnt_d == CNT_W'(N)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            seed_q        <= '0;
            eta4_q        <= 1'b0;
            abs_k_q       <= '0;
            buf_q         <= '0;
            ptr_q         <= '0;
            acc_cnt_q     <= '0;
            hs_cnt_q      <= '0;
            coeff_data_q  <= '0;
            coeff_idx_q   <= '0;
            coeff_valid_q <= 1'b0;
`ifdef REJ_CNT_EN
            rej_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            seed_q        <= seed_d;
            eta4_q        <= eta4_d;
            abs_k_q       <= abs_k_d;
            buf_q         <= buf_d;
            ptr_q         <= ptr_d;
            acc_cnt_q     <= acc_cnt_d;
            hs_cnt_q      <= hs_cnt_d;
            coeff_data_q  <= coeff_data_d;
            coeff_idx_q   <= coeff_idx_d;
            coeff_valid_q <= coeff_valid_d;
`ifdef REJ_CNT_EN
            rej_cnt_q     <= rej_cnt_d;
`endif
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        busy         = (state_q == S_INIT) || (state_q == S_ABSORB) ||
                       (state_q == S_FETCH) || (state_q == S_SAMPLE);
        done         = (state_q == S_DONE);
        sp_init      = (state_q == S_INIT);
        sp_in_valid  = (state_q == S_ABSORB);
        sp_in_last   = (state_q == S_ABSORB) && abs_last_word;
        sp_last_len  = '0;
        sp_data_in   = '0;
        if (state_q == S_ABSORB) begin
            sp_data_in = seed_pad[int'(abs_k_q)*DATA_IN_BITS +: DATA_IN_BITS];
            if (abs_last_word) begin
                sp_last_len = LEN_W'(LAST_BITS);
            end
        end
        sp_out_ready = (state_q == S_FETCH);
        coeff_data   = coeff_data_q;
        coeff_idx    = coeff_idx_q;
        coeff_valid  = coeff_valid_q;
    end

`ifdef REJ_CNT_EN
    assign rej_cnt = rej_cnt_q;
`endif

endmodule

// File: tb/tb_rej_bounded_sampler.sv
// Directed bench for rej_bounded_sampler with a simple sponge stand-in.
module tb_rej_bounded_sampler;

    localparam int NC = 256;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         eta_sel = 1'b0;
    logic [527:0] seed = '0;
    logic         busy, done;
    logic [3:0]   coeff_data;
    logic [7:0]   coeff_idx;
    logic         coeff_valid;
    logic         coeff_ready = 1'b1;
    logic         sp_init;
    logic [63:0]  sp_data_in;
    logic         sp_in_valid, sp_in_last;
    logic [6:0]   sp_last_len;
    logic         sp_in_ready = 1'b1;
    logic [63:0]  sp_data_out;
    logic         sp_out_valid = 1'b1;
    logic         sp_out_ready;
`ifdef REJ_CNT_EN
    logic [15:0]  rej_cnt;
`endif

    rej_bounded_sampler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .eta_sel(eta_sel), .seed(seed),
        .busy(busy), .done(done), .coeff_data(coeff_data), .coeff_idx(coeff_idx),
        .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .sp_init(sp_init),
        .sp_data_in(sp_data_in), .sp_in_valid(sp_in_valid), .sp_in_last(sp_in_last),
        .sp_last_len(sp_last_len), .sp_in_ready(sp_in_ready), .sp_data_out(sp_data_out),
        .sp_out_valid(sp_out_valid), .sp_out_ready(sp_out_ready)
`ifdef REJ_CNT_EN
        , .rej_cnt(rej_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // sponge stand-in: n_pre leading words, then fill_word forever
    logic [63:0] pre_words [0:3];
    int          n_pre = 0;
    logic [63:0] fill_word = '0;
    int          fetch_tot = 0;
    int          fetch_base = 0;

    always @* begin
        if ((fetch_tot - fetch_base) < n_pre)
            sp_data_out = pre_words[(fetch_tot - fetch_base) % 4];
        else
            sp_data_out = fill_word;
    end

    always @(posedge clk) begin
        if (sp_out_valid && sp_out_ready) fetch_tot <= fetch_tot + 1;
    end

    // recorders
    logic [63:0] abs_data [0:63];
    logic        abs_last [0:63];
    logic [6:0]  abs_len  [0:63];
    int          abs_tot = 0;
    logic [3:0]  rec_data [0:2047];
    logic [7:0]  rec_idx  [0:2047];
    int          coeff_tot = 0;
    int          init_tot = 0;
    int          done_tot = 0;

    always @(negedge clk) begin
        if (sp_in_valid && sp_in_ready && abs_tot < 64) begin
            abs_data[abs_tot] = sp_data_in;
            abs_last[abs_tot] = sp_in_last;
            abs_len[abs_tot]  = sp_last_len;
            abs_tot++;
        end
        if (sp_init) init_tot++;
        if (done) done_tot++;
        if (coeff_valid && coeff_ready && coeff_tot < 2048) begin
            rec_data[coeff_tot] = coeff_data;
            rec_idx[coeff_tot]  = coeff_idx;
            coeff_tot++;
        end
    end

    int abs_base, coeff_base, init_base, done_base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic e, input logic [527:0] s);
        @(posedge clk); #1;
        fetch_base = fetch_tot;
        coeff_base = coeff_tot;
        abs_base   = abs_tot;
        init_base  = init_tot;
        done_base  = done_tot;
        eta_sel = e;
        seed    = s;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(ok), 64'd1);
        @(negedge clk);
    endtask

    // mode 0: all +2; 1: first 1 then 4; 3: 2-(k%5); 4: 4-(k%9)
    task automatic check_run(input string tag, input int mode, input int fetches);
        int bad;
        logic [3:0] e;
        bad = 0;
        for (int k = 0; k < NC; k++) begin
            case (mode)
                0: e = 4'h2;
                1: e = (k == 0) ? 4'h1 : 4'h4;
                3: e = 4'(2 - (k % 5));
                default: e = 4'(4 - (k % 9));
            endcase
            if (rec_data[coeff_base + k] !== e || rec_idx[coeff_base + k] !== 8'(k)) bad++;
        end
        chk({tag, "_coeff_count"}, 64'(coeff_tot - coeff_base), 64'(NC));
        chk({tag, "_coeff_bad"}, 64'(bad), 64'd0);
        chk({tag, "_fetches"}, 64'(fetch_tot - fetch_base), 64'(fetches));
        chk({tag, "_init_pulses"}, 64'(init_tot - init_base), 64'd1);
        chk({tag, "_done_pulses"}, 64'(done_tot - done_base), 64'd1);
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    logic [527:0] seed_a;
    int           frozen_bad;
    bit           found;

    initial begin
        for (int i = 0; i < 66; i++) seed_a[i*8 +: 8] = 8'(i);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_coeff_valid", 64'(coeff_valid), 64'd0);
        chk("rst_sp_init", 64'(sp_init), 64'd0);
        chk("rst_sp_in_valid", 64'(sp_in_valid), 64'd0);
        chk("rst_sp_out_ready", 64'(sp_out_ready), 64'd0);
        chk("rst_coeff_idx", 64'(coeff_idx), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // run A: eta=2, absorb check, 4 all-reject words then zeros
        pre_words[0] = '1; pre_words[1] = '1; pre_words[2] = '1; pre_words[3] = '1;
        n_pre = 4; fill_word = '0;
        sp_in_ready = 1'b0;
        do_start(1'b0, seed_a);
        chk("A_busy_after_start", 64'(busy), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("A_absorb_hold_valid", 64'(sp_in_valid), 64'd1);
        chk("A_absorb_hold_data", sp_data_in, 64'h0706050403020100);
        sp_in_ready = 1'b1;
        wait_done("A", 3000);
        chk("A_absorb_words", 64'(abs_tot - abs_base), 64'd9);
        chk("A_word0", abs_data[abs_base], 64'h0706050403020100);
        chk("A_word7", abs_data[abs_base + 7], 64'h3F3E3D3C3B3A3938);
        chk("A_word8", abs_data[abs_base + 8], 64'h0000000000004140);
        chk("A_last_flag8", 64'(abs_last[abs_base + 8]), 64'd1);
        chk("A_last_flag7", 64'(abs_last[abs_base + 7]), 64'd0);
        chk("A_last_len", 64'(abs_len[abs_base + 8]), 64'd16);
        check_run("A", 0, 20);
`ifdef REJ_CNT_EN
        chk("A_rej_cnt", 64'(rej_cnt), 64'd64);
`endif

        // run B: eta=4, first byte 0x39, ignored restart, backpressure at idx 100
        pre_words[0] = 64'h39; n_pre = 1; fill_word = '0;
        do_start(1'b1, seed_a);
        start = 1'b1; eta_sel = 1'b0; seed = '1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk); #1;
            if (coeff_valid && coeff_idx == 8'd100) found = 1'b1;
        end
        chk("B_idx100_reached", 64'(found), 64'd1);
        coeff_ready = 1'b0;
        frozen_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (coeff_valid !== 1'b1 || coeff_idx !== 8'd100 || coeff_data !== 4'h4) frozen_bad++;
        end
        chk("B_stall_frozen", 64'(frozen_bad), 64'd0);
        coeff_ready = 1'b1;
        wait_done("B", 3000);
        chk("B_idx0_data", 64'(rec_data[coeff_base]), 64'h1);
        chk("B_idx1_data", 64'(rec_data[coeff_base + 1]), 64'h4);
        check_run("B", 1, 17);

        // run C: eta=2, byte 0xEF, reset at idx 50
        pre_words[0] = 64'hEF; n_pre = 1; fill_word = '0;
        do_start(1'b0, seed_a);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk); #1;
            if (coeff_valid && coeff_idx == 8'd50) found = 1'b1;
        end
        chk("C_idx50_reached", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("C_rst_busy", 64'(busy), 64'd0);
        chk("C_rst_valid", 64'(coeff_valid), 64'd0);
        chk("C_rst_idx", 64'(coeff_idx), 64'd0);
        chk("C_rst_data", 64'(coeff_data), 64'd0);
        chk("C_idx0_data", 64'(rec_data[coeff_base]), 64'hE);
        chk("C_idx1_data", 64'(rec_data[coeff_base + 1]), 64'h2);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // run D: eta=2, every word FEDCBA9876543210
        n_pre = 0; fill_word = 64'hFEDCBA9876543210;
        do_start(1'b0, seed_a);
        wait_done("D", 3000);
        check_run("D", 3, 18);
`ifdef REJ_CNT_EN
        chk("D_rej_cnt", 64'(rej_cnt), 64'd17);
`endif

        // run E: eta=4, same word
        do_start(1'b1, seed_a);
        wait_done("E", 3000);
        check_run("E", 4, 29);
`ifdef REJ_CNT_EN
        chk("E_rej_cnt", 64'(rej_cnt), 64'd196);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
